// File: rtl/aes_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the AES core, with a
// per-transfer watchdog that force-terminates strobes the slave never acks.
module aes_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  // master 0 (management port)
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [27:0] m0_addr,
  input  logic [31:0] m0_data_wr,
  output logic        m0_ack,
  output logic [31:0] m0_data_rd,
  // master 1 (secondary requester)
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [27:0] m1_addr,
  input  logic [31:0] m1_data_wr,
  output logic        m1_ack,
  output logic [31:0] m1_data_rd,
  // slave (AES core)
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [27:0] s_addr,
  output logic [31:0] s_data_wr,
  input  logic        s_ack,
  input  logic [31:0] s_data_rd,
  // status
  output logic [1:0]  grant,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state;
  logic               last;
  logic [CNT_W-1:0]   cnt;

  logic               owned;
  logic               own_cyc;
  logic               own_stb;
  logic               own_we;
  logic [3:0]         own_sel;
  logic [27:0]        own_addr;
  logic [31:0]        own_data_wr;
  logic               expire;
  logic               fwd_ack;
  logic [31:0]        fwd_data;

  // Select the current owner's request and derive watchdog expiry
  always_comb begin
    own_cyc     = m0_cyc;
    own_stb     = m0_stb;
    own_we      = m0_we;
    own_sel     = m0_sel;
    own_addr    = m0_addr;
    own_data_wr = m0_data_wr;
    if (state == OWN1) begin
      own_cyc     = m1_cyc;
      own_stb     = m1_stb;
      own_we      = m1_we;
      own_sel     = m1_sel;
      own_addr    = m1_addr;
      own_data_wr = m1_data_wr;
    end
    owned    = (state != IDLE);
    expire   = owned & (cnt == CNT_LAST) & own_stb & ~s_ack;
    // an ack seen while the owner's strobe is low, or during reset, is dropped
    fwd_ack  = owned & ~reset & ((own_stb & s_ack) | expire);
    fwd_data = expire ? TIMEOUT_DATA : s_data_rd;
  end

  // Forward the owner to the slave and route the response back to it only
  always_comb begin
    s_cyc      = owned & own_cyc;
    s_stb      = owned & own_stb & ~expire;
    s_we       = owned & own_we;
    s_sel      = owned ? own_sel : 4'h0;
    s_addr     = owned ? own_addr : 28'h0;
    s_data_wr  = owned ? own_data_wr : 32'h0;
    m0_ack     = (state == OWN0) & fwd_ack;
    m1_ack     = (state == OWN1) & fwd_ack;
    m0_data_rd = (state == OWN0) ? fwd_data : 32'h0;
    m1_data_rd = (state == OWN1) ? fwd_data : 32'h0;
  end

  // Arbitration FSM, watchdog counter, grant register and sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      cnt          <= '0;
      grant        <= 2'b00;
      timeout_flag <= 1'b0;
    end else begin
      if (expire) begin
        timeout_flag <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_cyc && (!m1_cyc || last)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1_cyc) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= (state == OWN1);
            cnt   <= '0;
          end else if (own_stb && !s_ack && !expire) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bus_arbiter.sv
// Self-checking bench for aes_bus_arbiter: directed table, hand sequences for
// lock / watchdog / reset corners, and a randomized run against a model.
module tb_aes_bus_arbiter;

  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] TDATA   = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [27:0] m0_addr;
  logic [31:0] m0_data_wr, m0_data_rd;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [27:0] m1_addr;
  logic [31:0] m1_data_wr, m1_data_rd;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [27:0] s_addr;
  logic [31:0] s_data_wr, s_data_rd;
  logic [1:0]  grant;
  logic        timeout_flag, timeout_clr;

  aes_bus_arbiter #(.TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TDATA)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_data_wr(m0_data_wr), .m0_ack(m0_ack), .m0_data_rd(m0_data_rd),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_data_wr(m1_data_wr), .m1_ack(m1_ack), .m1_data_rd(m1_data_rd),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_data_wr(s_data_wr), .s_ack(s_ack), .s_data_rd(s_data_rd),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, who released last, strobe cycles waited
  int   own     = -1;
  int   last_m  = 1;
  int   waited  = 0;
  logic flag_m  = 1'b0;
  logic exp_a [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_cyc(int i);
    return (i == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic logic m_stb(int i);
    return (i == 0) ? m0_stb : m1_stb;
  endfunction

  function automatic logic [66:0] bundle(int i);
    if (i == 0) return {m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_data_wr};
    return {m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_data_wr};
  endfunction

  // The TIMEOUT-th consecutive unanswered strobe cycle is terminated
  function automatic logic model_expire();
    if (own < 0) return 1'b0;
    return m_stb(own) && !s_ack && (waited + 1 == int'(TIMEOUT));
  endfunction

  // Compare every DUT output against the model for the current cycle
  task automatic eval();
    logic        x;
    logic [1:0]  eg;
    logic [66:0] es;
    logic        ea [2];
    logic [31:0] ed [2];
    #2;
    x  = model_expire();
    eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    es = '0;
    ea[0] = 1'b0; ea[1] = 1'b0;
    ed[0] = '0;   ed[1] = '0;
    if (own >= 0) begin
      es      = bundle(own);
      es[65]  = es[65] & ~x;
      ea[own] = !reset && ((m_stb(own) && s_ack) || x);
      ed[own] = x ? TDATA : s_data_rd;
    end
    exp_a[0] = ea[0];
    exp_a[1] = ea[1];
    chk("grant", 128'(grant), 128'(eg));
    chk("slave_bus", 128'({s_cyc, s_stb, s_we, s_sel, s_addr, s_data_wr}), 128'(es));
    chk("m0_resp", 128'({m0_ack, m0_data_rd}), 128'({ea[0], ed[0]}));
    chk("m1_resp", 128'({m1_ack, m1_data_rd}), 128'({ea[1], ed[1]}));
    chk("timeout_flag", 128'(timeout_flag), 128'(flag_m));
  endtask

  // Advance one clock, updating the model from the inputs held at the edge
  task automatic adv();
    logic x;
    @(posedge clock);
    x = model_expire();
    if (reset) begin
      own = -1; last_m = 1; waited = 0; flag_m = 1'b0;
    end else begin
      if (x) flag_m = 1'b1;
      else if (timeout_clr) flag_m = 1'b0;
      if (own < 0) begin
        waited = 0;
        if (m_cyc(0) && m_cyc(1)) own = 1 - last_m;
        else if (m_cyc(0))        own = 0;
        else if (m_cyc(1))        own = 1;
      end else if (!m_cyc(own)) begin
        last_m = own; own = -1; waited = 0;
      end else if (m_stb(own) && !s_ack && !x) begin
        waited++;
      end else begin
        waited = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_addr = '0; m0_data_wr = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_addr = '0; m1_data_wr = '0;
    s_ack = 0; s_data_rd = '0; timeout_clr = 0;
  endtask

  // Hold m0's strobe until the first ack; report on which strobe cycle it came
  task automatic wait_expire(output int hit);
    hit = 0;
    for (int k = 1; k <= 100; k++) begin
      eval();
      if (m0_ack === 1'b1) begin
        hit = k;
        chk("expire_data", 128'(m0_data_rd), 128'(TDATA));
        chk("expire_s_stb", 128'(s_stb), 128'(1'b0));
        adv();
        break;
      end
      adv();
    end
  endtask

  task automatic rnd_master(input logic cyc_i, input logic stb_i, input logic acked,
                            output logic cyc_o, output logic stb_o);
    cyc_o = cyc_i ? ($urandom % 15 != 0) : ($urandom % 6 == 0);
    if (!cyc_o)               stb_o = 1'b0;
    else if (stb_i && !acked) stb_o = 1'b1;
    else                      stb_o = ($urandom % 3 != 0);
  endtask

  typedef struct {
    logic       m0c, m0s, m1c, m1s, sack;
    logic [1:0] g;
    logic       a0, a1, sstb;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int  hit;
    logic c, s;

    // Four back-to-back contests: grants alternate m0, m1, m0, m1
    tbl[0]  = '{0,0,0,0,1, 2'b00, 0,0,0};
    tbl[1]  = '{1,0,1,0,0, 2'b00, 0,0,0};
    tbl[2]  = '{1,1,1,0,1, 2'b01, 1,0,1};
    tbl[3]  = '{0,0,1,0,1, 2'b01, 0,0,0};
    tbl[4]  = '{1,0,1,0,0, 2'b00, 0,0,0};
    tbl[5]  = '{1,0,1,1,1, 2'b10, 0,1,1};
    tbl[6]  = '{1,0,0,0,1, 2'b10, 0,0,0};
    tbl[7]  = '{1,0,1,0,0, 2'b00, 0,0,0};
    tbl[8]  = '{1,1,1,1,1, 2'b01, 1,0,1};
    tbl[9]  = '{0,0,1,0,0, 2'b01, 0,0,0};
    tbl[10] = '{1,0,1,0,0, 2'b00, 0,0,0};
    tbl[11] = '{1,0,1,1,1, 2'b10, 0,1,1};
    tbl[12] = '{0,0,0,0,0, 2'b10, 0,0,0};
    tbl[13] = '{0,0,0,0,1, 2'b00, 0,0,0};

    idle_inputs();
    reset = 1;
    adv(); adv();
    reset = 0;
    eval();
    chk("reset_grant", 128'(grant), 128'(2'b00));
    chk("reset_outputs", 128'({s_cyc, s_stb, m0_ack, m1_ack, m0_data_rd, m1_data_rd}), 128'(0));
    adv();

    for (int i = 0; i < 14; i++) begin
      m0_cyc = tbl[i].m0c; m0_stb = tbl[i].m0s;
      m1_cyc = tbl[i].m1c; m1_stb = tbl[i].m1s;
      s_ack  = tbl[i].sack; s_data_rd = 32'h0000_1000 + 32'(i);
      eval();
      chk($sformatf("tbl%0d_grant", i), 128'(grant), 128'(tbl[i].g));
      chk($sformatf("tbl%0d_acks", i), 128'({m0_ack, m1_ack, s_stb}),
          128'({tbl[i].a0, tbl[i].a1, tbl[i].sstb}));
      adv();
    end

    // Single master write
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_addr = 28'h000_0010; m0_data_wr = 32'h1234_5678;
    eval();
    chk("sm_idle_s_cyc", 128'(s_cyc), 128'(1'b0));
    adv();
    eval();
    chk("sm_grant", 128'(grant), 128'(2'b01));
    chk("sm_mirror", 128'({s_cyc, s_stb, s_we, s_addr, s_data_wr}),
        128'({1'b1, 1'b1, 1'b1, 28'h000_0010, 32'h1234_5678}));
    adv();
    s_ack = 1;
    eval();
    chk("sm_ack", 128'({m0_ack, m1_ack}), 128'(2'b10));
    adv();
    s_ack = 0; m0_stb = 0; m0_cyc = 0;
    eval(); adv();
    eval();
    chk("sm_release", 128'(grant), 128'(2'b00));
    adv();

    // Lock: m1 does three reads while m0 waits with cyc high
    idle_inputs();
    m1_cyc = 1;
    eval(); adv();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 3; i++) begin
      m1_stb = 1; s_ack = 1; s_data_rd = 32'hA + 32'(i);
      eval();
      chk($sformatf("lock_read%0d", i), 128'({grant, m1_ack, m1_data_rd, m0_ack}),
          128'({2'b10, 1'b1, 32'hA + 32'(i), 1'b0}));
      adv();
    end
    m1_stb = 0; m1_cyc = 0; s_ack = 0;
    eval();
    chk("lock_held", 128'(grant), 128'(2'b10));
    adv();
    eval();
    chk("lock_dead_cycle", 128'(grant), 128'(2'b00));
    adv();
    eval();
    chk("lock_m0_granted", 128'(grant), 128'(2'b01));
    adv();
    idle_inputs();
    eval(); adv();
    eval(); adv();

    // Watchdog: no slave ack at all
    m0_cyc = 1;
    eval(); adv();
    m0_stb = 1;
    wait_expire(hit);
    chk("timeout_cycle", 128'(hit), 128'(64));
    for (int k = 1; k <= 63; k++) begin
      eval();
      if (k == 1) chk("timeout_flag_set", 128'(timeout_flag), 128'(1'b1));
      adv();
    end
    timeout_clr = 1;
    eval();
    chk("expire2_ack", 128'(m0_ack), 128'(1'b1));
    adv();
    timeout_clr = 0;
    eval();
    chk("set_wins_over_clr", 128'(timeout_flag), 128'(1'b1));
    adv();
    m0_stb = 0; timeout_clr = 1;
    eval(); adv();
    timeout_clr = 0;
    eval();
    chk("flag_cleared", 128'(timeout_flag), 128'(1'b0));
    adv();

    // Ack on the 63rd strobe cycle beats the watchdog and clears the count
    m0_stb = 1;
    for (int k = 1; k <= 62; k++) begin
      eval(); adv();
    end
    s_ack = 1; s_data_rd = 32'h5555_AAAA;
    eval();
    chk("boundary_ack", 128'({m0_ack, m0_data_rd, s_stb}), 128'({1'b1, 32'h5555_AAAA, 1'b1}));
    adv();
    s_ack = 0;
    eval();
    chk("boundary_no_flag", 128'(timeout_flag), 128'(1'b0));
    adv();
    wait_expire(hit);
    chk("counter_cleared", 128'(hit), 128'(63));

    // Reset in the middle of an owned, strobing transfer
    reset = 1;
    eval(); adv();
    reset = 0; m1_cyc = 1;
    eval();
    chk("rst_mid_outputs", 128'({grant, s_cyc, s_stb, m0_ack, m1_ack, timeout_flag}), 128'(0));
    adv();
    eval();
    chk("rst_mid_m0_first", 128'(grant), 128'(2'b01));
    adv();
    idle_inputs();
    eval(); adv();
    eval(); adv();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd_master(m0_cyc, m0_stb, exp_a[0], c, s); m0_cyc = c; m0_stb = s;
      rnd_master(m1_cyc, m1_stb, exp_a[1], c, s); m1_cyc = c; m1_stb = s;
      m0_we = 1'($urandom); m0_sel = 4'($urandom); m0_addr = 28'($urandom); m0_data_wr = $urandom;
      m1_we = 1'($urandom); m1_sel = 4'($urandom); m1_addr = 28'($urandom); m1_data_wr = $urandom;
      s_ack       = ($urandom % 50 == 0);
      s_data_rd   = $urandom;
      timeout_clr = ($urandom % 40 == 0);
      reset       = ($urandom % 1500 == 0);
      eval();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_bus_arbiter.md
Name: aes_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the AES Wishbone core.
- Master 0 is the Caravel management Wishbone port. Master 1 is a secondary requester (LA-driven debug master / future DMA).
- Round-robin grant, held for the whole bus cycle (cyc). A per-transfer watchdog terminates hung slave accesses.
- Sits between accelerator_top's Wishbone inputs and the AES core bus port.

Parameters:
- TIMEOUT, 64, cycles a granted strobe may wait for slave ack before forced termination (legal range 2..65535).
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 Wishbone controls.
- m0_sel  in  4  master 0 byte selects.
- m0_addr  in  28  master 0 address.
- m0_data_wr  in  32  master 0 write data.
- m0_ack  out  1  master 0 acknowledge.
- m0_data_rd  out  32  master 0 read data.
- m1_*  same set and widths as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to AES core.
- s_sel  out  4  to AES core.
- s_addr  out  28  to AES core.
- s_data_wr  out  32  to AES core.
- s_ack  in  1  from AES core.
- s_data_rd  in  32  from AES core.
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.
- timeout_flag  out  1  sticky; set on any watchdog expiry.
- timeout_clr  in  1  clears timeout_flag.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. State, last-owner bit, watchdog counter and timeout_flag are registered.
- Reset: state=IDLE, last=1 (so m0 wins the first tie), counter=0, timeout_flag=0. All outputs are 0 (s_*, m*_ack, m*_data_rd, grant).
- Reset asserted mid-transfer aborts it: s_cyc drops the cycle after reset is sampled, and no ack is delivered to either master.
- IDLE transitions:
  - m0_cyc only -> OWN0.
  - m1_cyc only -> OWN1.
  - Both asserted -> the master not equal to last.
  - Neither -> stay in IDLE.
  - Arbitration latency: 1 cycle. The grant is visible the cycle after cyc is sampled. No slave signals are driven while in IDLE.
- OWNn forwarding (combinational from mn): s_cyc=mn_cyc, s_we, s_sel, s_addr, s_data_wr.
  - s_stb = mn_stb & ~expire.
  - mn_ack = s_ack | expire.
  - mn_data_rd = expire ? TIMEOUT_DATA : s_data_rd.
  - The non-owner always sees ack=0 and data_rd=0. Its requests wait; they are never dropped or reordered.
- Grant lock: the owner keeps the grant while mn_cyc=1, across any number of stb/ack pairs.
- Release: mn_cyc=0 in OWNn -> IDLE with last<=n. This costs one dead cycle before the next grant. A fresh request in IDLE on the following cycle then goes to the other master if both are pending.
- Watchdog:
  - Counter increments each cycle in OWNn with mn_stb=1 and s_ack=0.
  - Counter clears on s_ack, on ~mn_stb, and on leaving OWNn.
  - expire = (counter == TIMEOUT-1) & mn_stb & ~s_ack. This is a single-cycle termination: the master gets ack with TIMEOUT_DATA (writes are silently discarded) and s_stb is forced low that cycle.
  - On expire, timeout_flag<=1. The counter clears on expire. The grant is retained while cyc stays high.
- s_ack and expire in the same cycle cannot occur, because expire is qualified by ~s_ack. A real ack always wins.
- timeout_flag:
  - timeout_clr=1 clears it.
  - Set and clear in the same cycle -> set wins.
- grant output: registered one-hot of state. It never has both bits set.
- s_ack arriving in IDLE, or arriving with the owner's stb low, is ignored and not forwarded.

Test Plan:
- Single master: m0 writes addr 0x000_0010, data 0x1234_5678. Required: grant=01 one cycle after cyc; s_* mirror m0; m0_ack pulses with s_ack; m1_ack stays 0; grant returns to 00 after cyc drops.
- Simultaneous request after reset: m0 and m1 both raise cyc in the same cycle. Required: m0 granted first. After m0 releases, m1 is granted exactly 2 cycles after m0_cyc falls. On the next simultaneous request, m1 loses to... last=1, so m0 wins again. Over 4 repeated contests grants alternate m0, m1, m0, m1 (with last toggling on each release).
- Lock: m1 owns and performs 3 back-to-back reads while m0_cyc is held high. Required: all 3 reads complete on m1 (slave data 0xA, 0xB, 0xC delivered); m0 is granted only after m1_cyc drops.
- Timeout: slave never acks, TIMEOUT=64. Required: the owner's ack is asserted exactly on the 64th stb cycle with data_rd=0xDEADBEEF; s_stb is 0 that cycle; timeout_flag=1 and stays set. Then timeout_clr together with a new expiry in the same cycle leaves timeout_flag=1.
- Ack at the boundary: slave acks on cycle 63 of a wait. Required: normal ack with slave data, no timeout flag, counter cleared.
- Reset mid-transfer: assert reset while m0 owns with stb high. Required: the cycle after reset is sampled, all outputs are 0 and the state is IDLE. After reset release with both masters requesting, m0 is granted first.
